// File: rtl/ga_pkg.sv
// Shared types and defaults for the genetic-algorithm run controller.
// The sequencer state encoding and the datapath widths are used by the top and its testbench.
package ga_pkg;

  localparam int POP_W            = 7500;
  localparam int SEL_W            = 1500;
  localparam int DEF_GEN_W        = 16;
  localparam int DEF_MAX_GENS     = 100;
  localparam int DEF_REPORT_EVERY = 10;
  localparam int DEF_TIMEOUT      = 65535;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT_W = 4'd1,
    S_INIT_C = 4'd2,
    S_SEL_W  = 4'd3,
    S_MUT_W  = 4'd4,
    S_COMMIT = 4'd5,
    S_RPT_W  = 4'd6,
    S_DONE   = 4'd7,
    S_FAULT  = 4'd8
  } ga_state_e;

  function automatic logic is_wait_state(input ga_state_e s);
    logic w;
    case (s)
      S_INIT_W, S_SEL_W, S_MUT_W, S_RPT_W: w = 1'b1;
      default:                             w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ga_watchdog.sv
// Loadable down-counter that flags expiry when it runs out while a wait is in progress.
// Loaded with TIMEOUT-1 alongside every start strobe, decremented each cycle of a wait state.
module ga_watchdog
  import ga_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_q, count_d;

  // Reload beats decrement so a back-to-back wait starts a fresh budget.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (run && (count_q != ZERO)) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == ZERO);

endmodule

// File: rtl/ga_sequencer.sv
// Run-level controller: init, then selection -> mutation -> commit generations with
// periodic UART reports, stopping at the generation limit, on stop, or on watchdog expiry.
module ga_sequencer
  import ga_pkg::*;
#(
  parameter int GEN_W        = DEF_GEN_W,
  parameter int MAX_GENS     = DEF_MAX_GENS,
  parameter int REPORT_EVERY = DEF_REPORT_EVERY,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             init_done,
  input  logic             sel_done,
  input  logic             mut_done,
  input  logic             uart_done,
  output logic             init_start,
  output logic             sel_start,
  output logic             mut_start,
  output logic             uart_start,
  output logic             pop_we,
  output logic             pop_sel,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             finished,
  output logic             fault
);

  localparam logic [GEN_W-1:0] MAX_G   = GEN_W'(MAX_GENS);
  localparam logic [GEN_W-1:0] RPT_DIV = GEN_W'((REPORT_EVERY == 0) ? 1 : REPORT_EVERY);
  localparam logic             RPT_EN  = (REPORT_EVERY != 0);
  localparam logic [GEN_W-1:0] G_ZERO  = {GEN_W{1'b0}};

  if ((MAX_GENS < 1) || (64'(MAX_GENS) >= (64'd1 << GEN_W))) begin : g_bad_max_gens
    $error("ga_sequencer: MAX_GENS must be in 1..2^GEN_W-1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ga_sequencer: TIMEOUT must be at least 2");
  end

  ga_state_e        state_q, state_d;
  logic             init_start_q, init_start_d;
  logic             sel_start_q, sel_start_d;
  logic             mut_start_q, mut_start_d;
  logic             uart_start_q, uart_start_d;
  logic             pop_we_q, pop_we_d;
  logic             pop_sel_q, pop_sel_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             busy_q, busy_d;
  logic             finished_q, finished_d;
  logic             fault_q, fault_d;
  logic             stop_lat_q, stop_lat_d;

  logic done_s, first_s, accept_s, last_gen_s, report_due_s;
  logic wd_load_s, wd_run_s, wd_expired_s;

  // The strobe flop doubles as the "first cycle of this wait" marker, so done is masked there.
  always_comb begin
    done_s  = 1'b0;
    first_s = 1'b0;
    case (state_q)
      S_INIT_W: begin done_s = init_done; first_s = init_start_q; end
      S_SEL_W:  begin done_s = sel_done;  first_s = sel_start_q;  end
      S_MUT_W:  begin done_s = mut_done;  first_s = mut_start_q;  end
      S_RPT_W:  begin done_s = uart_done; first_s = uart_start_q; end
      default:  begin done_s = 1'b0;      first_s = 1'b0;         end
    endcase
  end

  assign accept_s     = done_s && !first_s;
  assign last_gen_s   = (gen_count_q == MAX_G);
  assign report_due_s = (RPT_EN && ((gen_count_q % RPT_DIV) == G_ZERO)) || last_gen_s || stop;
  assign wd_run_s     = is_wait_state(state_q);
  assign wd_load_s    = init_start_d | sel_start_d | mut_start_d | uart_start_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    init_start_d = 1'b0;
    sel_start_d  = 1'b0;
    mut_start_d  = 1'b0;
    uart_start_d = 1'b0;
    pop_we_d     = 1'b0;
    pop_sel_d    = pop_sel_q;
    gen_count_d  = gen_count_q;
    busy_d       = busy_q;
    finished_d   = finished_q;
    fault_d      = fault_q;
    stop_lat_d   = stop_lat_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_INIT_W;
          init_start_d = 1'b1;
          gen_count_d  = G_ZERO;
          finished_d   = 1'b0;
          busy_d       = 1'b1;
          stop_lat_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_INIT_W: begin
        if (accept_s) begin
          state_d   = S_INIT_C;
          pop_we_d  = 1'b1;
          pop_sel_d = 1'b0;
        end else if (wd_expired_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_INIT_W;
        end
      end
      S_INIT_C: begin
        state_d     = S_SEL_W;
        sel_start_d = 1'b1;
      end
      S_SEL_W: begin
        if (accept_s) begin
          state_d     = S_MUT_W;
          mut_start_d = 1'b1;
        end else if (wd_expired_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_SEL_W;
        end
      end
      S_MUT_W: begin
        if (accept_s) begin
          state_d     = S_COMMIT;
          pop_we_d    = 1'b1;
          pop_sel_d   = 1'b1;
          gen_count_d = gen_count_q + GEN_W'(1);
        end else if (wd_expired_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_MUT_W;
        end
      end
      S_COMMIT: begin
        // gen_count_q already holds the new count here.
        stop_lat_d = stop;
        if (report_due_s) begin
          state_d      = S_RPT_W;
          uart_start_d = 1'b1;
        end else begin
          state_d     = S_SEL_W;
          sel_start_d = 1'b1;
        end
      end
      S_RPT_W: begin
        if (accept_s && (last_gen_s || stop_lat_q)) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          finished_d = 1'b1;
        end else if (accept_s) begin
          state_d     = S_SEL_W;
          sel_start_d = 1'b1;
        end else if (wd_expired_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RPT_W;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      init_start_q <= 1'b0;
      sel_start_q  <= 1'b0;
      mut_start_q  <= 1'b0;
      uart_start_q <= 1'b0;
      pop_we_q     <= 1'b0;
      pop_sel_q    <= 1'b0;
      gen_count_q  <= G_ZERO;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      fault_q      <= 1'b0;
      stop_lat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_start_q <= init_start_d;
      sel_start_q  <= sel_start_d;
      mut_start_q  <= mut_start_d;
      uart_start_q <= uart_start_d;
      pop_we_q     <= pop_we_d;
      pop_sel_q    <= pop_sel_d;
      gen_count_q  <= gen_count_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      fault_q      <= fault_d;
      stop_lat_q   <= stop_lat_d;
    end
  end

  ga_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load_s),
    .run    (wd_run_s),
    .expired(wd_expired_s)
  );

  assign init_start = init_start_q;
  assign sel_start  = sel_start_q;
  assign mut_start  = mut_start_q;
  assign uart_start = uart_start_q;
  assign pop_we     = pop_we_q;
  assign pop_sel    = pop_sel_q;
  assign gen_count  = gen_count_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_ga_sequencer.sv
// Self-checking bench: two sequencer configurations driven by randomized done responders
// and checked against an event-level model of a run (strobe order, timing, gen_count).
module tb_ga_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, start_v, stop_v, init_done_v, sel_done_v, mut_done_v, uart_done_v;
  logic [1:0]  init_start_v, sel_start_v, mut_start_v, uart_start_v;
  logic [1:0]  pop_we_v, pop_sel_v, busy_v, finished_v, fault_v;
  logic [15:0] gen_count_v [2];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ga_sequencer #(.GEN_W(16), .MAX_GENS(3), .REPORT_EVERY(0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]),
    .init_done(init_done_v[0]), .sel_done(sel_done_v[0]), .mut_done(mut_done_v[0]),
    .uart_done(uart_done_v[0]), .init_start(init_start_v[0]), .sel_start(sel_start_v[0]),
    .mut_start(mut_start_v[0]), .uart_start(uart_start_v[0]), .pop_we(pop_we_v[0]),
    .pop_sel(pop_sel_v[0]), .gen_count(gen_count_v[0]), .busy(busy_v[0]),
    .finished(finished_v[0]), .fault(fault_v[0]));

  ga_sequencer #(.GEN_W(16), .MAX_GENS(6), .REPORT_EVERY(2), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]),
    .init_done(init_done_v[1]), .sel_done(sel_done_v[1]), .mut_done(mut_done_v[1]),
    .uart_done(uart_done_v[1]), .init_start(init_start_v[1]), .sel_start(sel_start_v[1]),
    .mut_start(mut_start_v[1]), .uart_start(uart_start_v[1]), .pop_we(pop_we_v[1]),
    .pop_sel(pop_sel_v[1]), .gen_count(gen_count_v[1]), .busy(busy_v[1]),
    .finished(finished_v[1]), .fault(fault_v[1]));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] flags(input int d);
    return {init_start_v[d], sel_start_v[d], mut_start_v[d], uart_start_v[d], pop_we_v[d],
            pop_sel_v[d], busy_v[d], finished_v[d], fault_v[d]};
  endfunction

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_flags"}, 32'(flags(d)), 32'd0);
    chk({tag, "_gen_count"}, 32'(gen_count_v[d]), 32'd0);
  endtask

  // Event codes: 0 init, 1 sel, 2 mut, 3 uart, 4 pop commit of init, 5 pop commit of mutants.
  function automatic int observe(input int d);
    int n;
    n = int'(init_start_v[d]) + int'(sel_start_v[d]) + int'(mut_start_v[d]) +
        int'(uart_start_v[d]) + int'(pop_we_v[d]);
    if (n == 0) return -1;
    if (n > 1) return 9;
    if (init_start_v[d]) return 0;
    if (sel_start_v[d]) return 1;
    if (mut_start_v[d]) return 2;
    if (uart_start_v[d]) return 3;
    return pop_sel_v[d] ? 5 : 4;
  endfunction

  task automatic clear_inputs(input int d);
    start_v[d] = 1'b0; stop_v[d] = 1'b0;
    init_done_v[d] = 1'b0; sel_done_v[d] = 1'b0; mut_done_v[d] = 1'b0; uart_done_v[d] = 1'b0;
  endtask

  // One run: stop_gen = generation whose commit sees stop (0 = never, 1 = raised during init),
  // early_pct = chance a done is raised in the strobe cycle, abort_mut = reset in that MUT_W.
  task automatic run(input int d, input int stop_gen, input int early_pct, input int abort_mut);
    int ek[$];
    int eg[$];
    int max_g, re, g, final_g, exp_at, pend_cycle, pend_kind, ev, kind, muts;
    logic pend, early_now, dn, ok;
    max_g = (d == 0) ? 3 : 6;
    re    = (d == 0) ? 0 : 2;
    ek.push_back(0); eg.push_back(0);
    ek.push_back(4); eg.push_back(0);
    final_g = 0;
    for (g = 1; g <= max_g; g++) begin
      ek.push_back(1); eg.push_back(g - 1);
      ek.push_back(2); eg.push_back(g - 1);
      ek.push_back(5); eg.push_back(g);
      final_g = g;
      if ((re != 0 && g % re == 0) || g == max_g || (stop_gen != 0 && g >= stop_gen)) begin
        ek.push_back(3); eg.push_back(g);
      end
      if (g == max_g || (stop_gen != 0 && g >= stop_gen)) break;
    end
    stop_v[d]  = (stop_gen == 1);
    start_v[d] = 1'b1;
    exp_at = cyc + 1;
    step();
    start_v[d] = 1'b0;
    pend = 1'b0; early_now = 1'b0; pend_cycle = 0; pend_kind = 0; muts = 0; ok = 1'b0;
    for (int guard = 0; guard < 3000; guard++) begin
      ev = observe(d);
      if (ek.size() == 0 && cyc >= exp_at) begin
        clear_inputs(d);
        chk("done_finished", 32'(finished_v[d]), 32'd1);
        chk("done_busy", 32'(busy_v[d]), 32'd0);
        chk("done_gen_count", 32'(gen_count_v[d]), 32'(final_g));
        chk("done_quiet", 32'(ev), 32'(-1));
        ok = 1'b1;
        break;
      end
      if (ek.size() != 0 && (ev != -1 || cyc >= exp_at)) begin
        chk("event_kind", 32'(ev), 32'(ek[0]));
        chk("event_cycle", 32'(cyc), 32'(exp_at));
        chk("event_busy", 32'(busy_v[d]), 32'd1);
        chk("event_gen_count", 32'(gen_count_v[d]), 32'(eg[0]));
        if (ek[0] == 0) chk("init_finished", 32'(finished_v[d]), 32'd0);
        kind = ek.pop_front();
        void'(eg.pop_front());
        if (kind <= 3) begin
          pend = 1'b1;
          pend_kind = kind;
          early_now = ($urandom_range(0, 99) < early_pct);
          pend_cycle = cyc + (early_now ? 1 : int'($urandom_range(1, 6)));
          exp_at = pend_cycle + 1;
        end else begin
          exp_at = cyc + 1;
        end
        if (kind == 2) begin
          muts++;
          if (stop_gen > 1 && muts == stop_gen) stop_v[d] = 1'b1;
          if (muts == abort_mut) begin
            clear_inputs(d);
            rst_v[d] = 1'b1;
            step();
            chk_reset(d, "abort_reset");
            rst_v[d] = 1'b0;
            step();
            return;
          end
        end
      end
      dn = pend && (cyc == pend_cycle || (early_now && cyc == pend_cycle - 1));
      init_done_v[d] = dn && (pend_kind == 0);
      sel_done_v[d]  = dn && (pend_kind == 1);
      mut_done_v[d]  = dn && (pend_kind == 2);
      uart_done_v[d] = dn && (pend_kind == 3);
      start_v[d]     = ($urandom_range(0, 7) == 0);
      step();
    end
    clear_inputs(d);
    chk("run_completed", 32'(ok), 32'd1);
  endtask

  initial begin
    int sc;
    rst_v = 2'b11;
    clear_inputs(0);
    clear_inputs(1);
    step();
    step();
    chk_reset(0, "reset_a");
    chk_reset(1, "reset_b");
    rst_v = 2'b00;
    step();

    run(0, 0, 0, 0);      // nominal, report only at the end
    run(0, 0, 100, 0);    // every done raised in its strobe cycle
    run(1, 0, 25, 0);     // periodic reports at 2, 4, 6
    run(1, 2, 25, 0);     // stop during 2nd MUT_W, restart from DONE
    run(1, 3, 25, 0);     // stop forces an off-period report
    run(1, 1, 25, 0);     // stop during init acts after first commit
    run(1, 0, 25, 2);     // reset in 2nd MUT_W
    run(1, 0, 50, 0);     // clean run after abort
    for (int i = 0; i < 4; i++) begin
      run(1, int'($urandom_range(0, 6)), int'($urandom_range(0, 100)), 0);
    end

    // Watchdog: sel_done never arrives.
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("to_init_start", 32'(init_start_v[0]), 32'd1);
    step();
    init_done_v[0] = 1'b1;
    step();
    init_done_v[0] = 1'b0;
    chk("to_pop_we", 32'(pop_we_v[0]), 32'd1);
    chk("to_pop_sel", 32'(pop_sel_v[0]), 32'd0);
    step();
    chk("to_sel_start", 32'(sel_start_v[0]), 32'd1);
    sc = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fault_v[0]) break;
    end
    chk("to_latency", 32'(cyc - sc), 32'd16);
    chk("to_fault_flags", 32'(flags(0)), 32'd1);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    chk("to_start_ignored", 32'(flags(0)), 32'd1);
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    chk_reset(0, "to_rst");
    run(0, 0, 30, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ga_sequencer.md
Name: ga_sequencer

Overview:
- Run-level controller for the genetic-algorithm datapath.
- Sequences population init, then repeated selection -> mutation -> population commit generations, with periodic UART reporting of the selected population.
- Drives the population register write strobe/mux, counts generations and stops at a limit, on an external stop request or on a sub-module watchdog timeout.
- Sits between the button pulser and the InitPop / Selection / Mutation / UART spitter blocks.

Parameters:
- GEN_W, 16, width of generation counter.
- MAX_GENS, 100, generations per run (1..2^GEN_W-1).
- REPORT_EVERY, 10, issue a UART report every N committed generations; 0 = report only at the final generation.
- TIMEOUT, 65535, max cycles to wait for any done before fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle run request (from button pulser)
- stop  in  1  level; finish run after current commit
- init_done  in  1  InitPop finished
- sel_done  in  1  Selection finished
- mut_done  in  1  Mutation finished
- uart_done  in  1  UART spitter finished
- init_start  out  1  one-cycle strobe
- sel_start  out  1  one-cycle strobe
- mut_start  out  1  one-cycle strobe
- uart_start  out  1  one-cycle strobe
- pop_we  out  1  population register write enable, one cycle
- pop_sel  out  1  0 = load init population, 1 = load mutant population
- gen_count  out  GEN_W  committed generations this run
- busy  out  1  run in progress
- finished  out  1  run completed normally (held)
- fault  out  1  watchdog expired (sticky)

Behaviour:
- Reset: state IDLE; all strobes 0, pop_we 0, pop_sel 0, gen_count 0, busy 0, finished 0, fault 0, watchdog 0.
- States: IDLE, INIT_W, INIT_C, SEL_W, MUT_W, COMMIT, RPT_W, DONE, FAULT.
- All outputs registered.
- A start strobe is high only in the first cycle of its wait state. The matching done is ignored in that cycle and accepted from the next cycle on, at level high.
- Transition on the accepting edge; the next strobe appears in the following cycle (1-cycle turnaround).
- IDLE/DONE + start -> INIT_W (init_start=1). On this transition: gen_count=0, finished=0, busy=1.
- start is ignored in every other state.
- INIT_W + init_done -> INIT_C: pop_we=1, pop_sel=0 for one cycle, then SEL_W (sel_start=1).
- SEL_W + sel_done -> MUT_W (mut_start=1).
- MUT_W + mut_done -> COMMIT: pop_we=1, pop_sel=1, gen_count increments by 1 in the same cycle. Next state, using the new count g:
  - RPT_W (uart_start=1) if (REPORT_EVERY!=0 and g mod REPORT_EVERY==0), or g==MAX_GENS, or stop=1.
  - otherwise SEL_W.
- RPT_W + uart_done -> DONE if g==MAX_GENS or stop was latched at COMMIT; else SEL_W.
- DONE: busy=0, finished=1 held until the next start.
- stop is sampled only in COMMIT. A stop asserted during the init phase takes effect after the first commit.
- Watchdog:
  - Clears on every strobe and counts in each *_W state.
  - On reaching TIMEOUT-1 without done -> FAULT: fault=1, busy=0, all strobes 0.
  - FAULT is left only by rst.
- gen_count never exceeds MAX_GENS. Rollover is impossible by parameter constraint, and elaboration asserts MAX_GENS < 2^GEN_W.
- rst mid-run aborts immediately to reset values. Sub-modules are not notified; they must also reset.
- pop_sel holds its last value when pop_we=0.

Decomposition:
- Package ga_pkg:
  - state enum encoding.
  - POP_W=7500, SEL_W=1500 population widths.
  - Default GEN_W/MAX_GENS/TIMEOUT constants shared with Top.
- One sub-module, ga_watchdog: loadable down-counter with clear and expire outputs.
- Everything else stays in ga_sequencer.

Test Plan:
- Nominal run, MAX_GENS=3, REPORT_EVERY=0, each done 5 cycles after its strobe -> strobe order init, sel, mut, sel, mut, sel, mut, uart. pop_we pulses 4 times (pop_sel 0,1,1,1). gen_count ends at 3, then finished=1, busy=0.
- Periodic reports, MAX_GENS=6, REPORT_EVERY=2 -> uart_start after commits with gen_count 2, 4, 6 only; finished after the third uart_done.
- Early done: done held high from the strobe cycle onward -> accepted exactly one cycle after the strobe, with no double transition.
- stop=1 during the 2nd MUT_W (MAX_GENS=10) -> one report at gen_count=2, then DONE. A new start restarts with gen_count=0 and init_start.
- Timeout, TIMEOUT=16, sel_done never asserted -> fault=1 exactly 16 cycles after sel_start, busy=0. start is then ignored; rst clears fault.
- rst asserted in MUT_W -> next cycle all outputs at reset values; state IDLE.
